// File: rtl/wino_pkg.sv
// Shared types and arithmetic helpers for the Winograd F(2,3) streaming engine.
// Helpers work on 64-bit values; callers size the results down to their datapath widths.
package wino_pkg;

   // Register ranks: s1 (V/U), s2 (products), s3 (transformed sums), output (reduced Z).
   localparam int STAGES = 4;

   typedef struct packed {
      longint q0;
      longint q1;
      longint q2;
      longint q3;
   } quad_t;

   typedef struct packed {
      longint y0;
      longint y1;
   } pair_t;

   function automatic quad_t in_xform(input longint d0, input longint d1,
                                      input longint d2, input longint d3);
      quad_t v;
      v.q0 = d0 - d2;
      v.q1 = d1 + d2;
      v.q2 = d2 - d1;
      v.q3 = d1 - d3;
      return v;
   endfunction

   // Filter transform is scaled by 2 so it stays integer; out_xform halves it back.
   function automatic quad_t filt_xform(input longint g0, input longint g1, input longint g2);
      quad_t u;
      u.q0 = 2 * g0;
      u.q1 = g0 + g1 + g2;
      u.q2 = g0 - g1 + g2;
      u.q3 = 2 * g2;
      return u;
   endfunction

   function automatic pair_t out_xform(input longint m0, input longint m1,
                                       input longint m2, input longint m3);
      pair_t p;
      p.y0 = (m0 + m1 + m2) >>> 1;
      p.y1 = (m1 - m2 - m3) >>> 1;
      return p;
   endfunction

   // Clamp to a signed w-bit range, or wrap by sign-extending the low w bits.
   function automatic longint sat_wrap(input longint x, input int w, input bit sat);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (sat) begin
         if (x > hi) return hi;
         if (x < lo) return lo;
         return x;
      end
      return (x <<< (64 - w)) >>> (64 - w);
   endfunction

endpackage

// File: rtl/wino_f23_datapath.sv
// Back end of the F(2,3) pipeline: element-wise multiply, output transform, OW reduction.
// Each rank loads only when the pipe advances and the rank feeding it holds a tile.
module wino_f23_datapath
   import wino_pkg::*;
#(
   parameter int DW  = 10,
   parameter int GW  = 8,
   parameter int OW  = 10,
   parameter int CW  = 2,
   parameter int SAT = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [3:1]            vld,
   input  logic [3:0][DW:0]      v,
   input  logic [3:0][GW+1:0]    u,
   input  logic [CW-1:0]         ch,
   output logic [2*OW-1:0]       z,
   output logic [CW-1:0]         z_ch
);
   localparam int MW = DW + GW + 3;
   localparam int SW = DW + GW + 5;

   logic [3:0][MW-1:0] m_new;
   logic [3:0][MW-1:0] s2_m;
   logic [CW-1:0]      s2_ch;
   logic [SW-1:0]      s3_y0, s3_y1;
   logic [CW-1:0]      s3_ch;
   pair_t              yq;
   logic [OW-1:0]      z0_new, z1_new;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [MW-1:0] va, ua;
      assign va = MW'($signed(v[gi]));
      assign ua = MW'($signed(u[gi]));
      assign m_new[gi] = va * ua;
   end

   always_comb begin
      yq = out_xform(longint'($signed(s2_m[0])), longint'($signed(s2_m[1])),
                     longint'($signed(s2_m[2])), longint'($signed(s2_m[3])));
      z0_new = OW'(sat_wrap(longint'($signed(s3_y0)), OW, SAT != 0));
      z1_new = OW'(sat_wrap(longint'($signed(s3_y1)), OW, SAT != 0));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_m  <= '0;
         s2_ch <= '0;
      end else if (en && vld[1]) begin
         s2_m  <= m_new;
         s2_ch <= ch;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_y0 <= '0;
         s3_y1 <= '0;
         s3_ch <= '0;
      end else if (en && vld[2]) begin
         s3_y0 <= SW'(yq.y0);
         s3_y1 <= SW'(yq.y1);
         s3_ch <= s2_ch;
      end
   end

   // Output rank holds while stalled, so Z is stable under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z    <= '0;
         z_ch <= '0;
      end else if (en && vld[3]) begin
         z    <= {z0_new, z1_new};
         z_ch <= s3_ch;
      end
   end

endmodule

// File: rtl/wino_f23_stream.sv
// Streaming Winograd F(2,3) engine: per-channel transformed-filter store, input transform
// stage, valid/ready handshake; multiply and output transform live in the datapath.
module wino_f23_stream
   import wino_pkg::*;
#(
   parameter int  DW  = 10,
   parameter int  GW  = 8,
   parameter int  OW  = 10,
   parameter int  NCH = 4,
   parameter int  SAT = 1,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                w_we,
   input  logic [CW-1:0]       w_ch,
   input  logic [3*GW-1:0]     w_g,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW-1:0]       in_ch,
   input  logic [4*DW-1:0]     D,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW-1:0]       out_ch,
   output logic [2*OW-1:0]     Z
);
   localparam int UW = GW + 2;
   localparam int VW = DW + 1;

   logic [NCH-1:0][3:0][UW-1:0] u_mem;
   logic [3:0][UW-1:0]          u_new, u_sel, s1_u;
   logic [3:0][VW-1:0]          v_new, s1_v;
   logic [CW-1:0]               s1_ch;
   logic [STAGES:1]             vld_pipe;
   logic                        en, accept;
   quad_t                       uq, vq;

   assign en        = !vld_pipe[STAGES] || out_ready;
   assign in_ready  = rst && en;
   assign accept    = in_valid && in_ready;
   assign out_valid = vld_pipe[STAGES];

   always_comb begin
      uq = filt_xform(longint'($signed(w_g[3*GW-1 -: GW])),
                      longint'($signed(w_g[2*GW-1 -: GW])),
                      longint'($signed(w_g[GW-1:0])));
      vq = in_xform(longint'($signed(D[4*DW-1 -: DW])), longint'($signed(D[3*DW-1 -: DW])),
                    longint'($signed(D[2*DW-1 -: DW])), longint'($signed(D[DW-1:0])));
      u_new = {UW'(uq.q3), UW'(uq.q2), UW'(uq.q1), UW'(uq.q0)};
      v_new = {VW'(vq.q3), VW'(vq.q2), VW'(vq.q1), VW'(vq.q0)};
   end

   // Channels with no filter slot select zero weights, which forces a zero result.
   always_comb begin
      u_sel = '0;
      for (int i = 0; i < NCH; i++)
         if (in_ch == CW'(i)) u_sel = u_mem[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         u_mem <= '0;
      end else if (w_we) begin
         for (int i = 0; i < NCH; i++)
            if (w_ch == CW'(i)) u_mem[i] <= u_new;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
   end

   // U is captured with V, so later weight writes never reach tiles already accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v  <= '0;
         s1_u  <= '0;
         s1_ch <= '0;
      end else if (accept) begin
         s1_v  <= v_new;
         s1_u  <= u_sel;
         s1_ch <= in_ch;
      end
   end

   wino_f23_datapath #(
      .DW  (DW),
      .GW  (GW),
      .OW  (OW),
      .CW  (CW),
      .SAT (SAT)
   ) u_dp (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .vld  (vld_pipe[STAGES-1:1]),
      .v    (s1_v),
      .u    (s1_u),
      .ch   (s1_ch),
      .z    (Z),
      .z_ch (out_ch)
   );

endmodule
